program_loader: RTL and testbench

// - Writer side of the byte-array program memory that feeds the ROM read port on the motherboard.
// - Accepts a byte stream over a valid/ready handshake and stores it into a 2**ADDR_WIDTH-byte array.
// - Drives the array as a flat bus: byte i at mem[i*8 +: 8].
// - Holds the CPU in reset (cpu_hold) until a load completes.

---
 rtl/program_loader.sv | 162 ++++++++++++++++
 tb/tb_program_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//   Writer side of the byte-array program memory behind the ROM read port.
//   A byte stream arriving over a valid/ready handshake is written into a
//   2**ADDR_WIDTH-byte array, starting at base_addr and wrapping at the top.
//   The CPU stays in reset (cpu_hold) until a load finishes cleanly.
//
//   Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//     When it is defined, one trailing checksum byte follows the payload. It
//     is not stored. error is set when (payload sum + checksum) mod 256 != 0.
//     When it is undefined, there is no CHECK state and error is tied to 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   begin a load; only sampled in IDLE or DONE
//   base_addr  in   first byte address, sampled with start
//   count      in   payload byte count 0..2**ADDR_WIDTH, sampled with start
//   in_data    in   stream byte
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts in_data
//   mem        out  flat array, byte i at mem[i*8 +: 8]
//   cpu_hold   out  active-high CPU reset
//   busy       out  load in progress
//   done       out  sticky, last load finished
//   error      out  sticky, checksum mismatch on last load
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | after reset, waiting for the first start
// LOAD  | accepting payload bytes into mem
// CHECK | accepting the trailing checksum byte (checksum build)
// DONE  | load finished, waiting for the next start

module program_loader #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [ADDR_WIDTH:0]           count,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [(2**ADDR_WIDTH)*8-1:0]  mem,
  output logic                          cpu_hold,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHECK = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  last_payload;

  // The payload ends either immediately (count = 0, no transfer) or on the
  // transfer of the final byte.
  assign last_payload = (remaining == '0) || (in_valid && remaining == REM_ONE);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] check_sum;
  logic       error_q;

  assign check_sum = sum + in_data;
  assign error     = error_q;
`else
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem       <= '0;
      wr_addr   <= '0;
      remaining <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_hold  <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum       <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            wr_addr   <= base_addr;
            remaining <= count;
            // With count = 0 nothing may be accepted in LOAD, so keep the
            // handshake closed for that one cycle.
            in_ready  <= (count != '0);
            busy      <= 1'b1;
            done      <= 1'b0;
            cpu_hold  <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum       <= '0;
            error_q   <= 1'b0;
`endif
          end
        end

        LOAD: begin
          if (remaining != '0 && in_valid) begin
            mem[{wr_addr, 3'b000} +: 8] <= in_data;
            wr_addr   <= wr_addr + 1'b1;
            remaining <= remaining - REM_ONE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum       <= sum + in_data;
`endif
          end
          if (last_payload) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state    <= CHECK;
            in_ready <= 1'b1;
`else
            state    <= DONE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (in_valid) begin
            state    <= DONE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            error_q  <= (check_sum != 8'h00);
            cpu_hold <= (check_sum != 8'h00);
          end
        end
`endif

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;
  localparam int MW    = DEPTH*8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] mem;
  logic          cpu_hold, busy, done, error;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .mem(mem),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic [MW-1:0] data;
    int            gap;
    logic          ck_bad;
  } vec_t;

  typedef struct {
    logic [MW-1:0] mem;
    logic          err;
  } exp_t;

  vec_t          vecs[6];
  exp_t          sb[$];
  logic [MW-1:0] model_mem;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic begin_load(input logic [AW-1:0] b, input logic [AW:0] c);
    @(negedge clk);
    start = 1'b1; base_addr = b; count = c;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", MW'(busy), MW'(1'b1));
    chk("start_done", MW'(done), MW'(1'b0));
    chk("start_hold", MW'(cpu_hold), MW'(1'b1));
    chk("start_error", MW'(error), MW'(1'b0));
    if (c != '0) chk("start_in_ready", MW'(in_ready), MW'(1'b1));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_data = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual in_ready=0 expected in_ready=1 within 20 cycles");
    end
  endtask

  task automatic finish_load(input string name);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_done"}, MW'(done), MW'(1'b1));
    chk({name, "_busy"}, MW'(busy), MW'(1'b0));
    chk({name, "_in_ready"}, MW'(in_ready), MW'(1'b0));
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard actual=empty expected=entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_mem"}, mem, e.mem);
      chk({name, "_error"}, MW'(error), MW'(e.err));
      chk({name, "_hold"}, MW'(cpu_hold), MW'(e.err));
    end
  endtask

  function automatic logic [7:0] ck_byte(input logic [7:0] sum, input logic bad);
    logic [7:0] good;
    good = 8'h00 - sum;
    return bad ? good + 8'h03 : good;
  endfunction

  function automatic logic [7:0] payload_sum(input vec_t v);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < int'(v.cnt); i++) s = s + v.data[i*8 +: 8];
    return s;
  endfunction

  task automatic push_expect(input vec_t v);
    exp_t e;
    for (int i = 0; i < int'(v.cnt); i++)
      model_mem[((int'(v.base) + i) % DEPTH)*8 +: 8] = v.data[i*8 +: 8];
    e.mem = model_mem;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    e.err = v.ck_bad;
`else
    e.err = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    push_expect(v);
    begin_load(v.base, v.cnt);
    for (int i = 0; i < int'(v.cnt); i++) send_byte(v.data[i*8 +: 8], v.gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(ck_byte(payload_sum(v), v.ck_bad), 0);
`endif
    finish_load(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{base: 4'd0,  cnt: 5'd4,  data: 128'h44332211, gap: 0, ck_bad: 1'b0};
    vecs[1] = '{base: 4'd14, cnt: 5'd3,  data: 128'hCCBBAA,   gap: 2, ck_bad: 1'b0};
    vecs[2] = '{base: 4'd5,  cnt: 5'd0,  data: 128'h0,        gap: 0, ck_bad: 1'b0};
    vecs[3] = '{base: 4'd0,  cnt: 5'd16, data: 128'h0,        gap: 0, ck_bad: 1'b0};
    vecs[4] = '{base: 4'd3,  cnt: 5'd2,  data: 128'h0201,     gap: 1, ck_bad: 1'b0};
    vecs[5] = '{base: 4'd3,  cnt: 5'd2,  data: 128'h0201,     gap: 0, ck_bad: 1'b1};
    for (int i = 0; i < DEPTH; i++) vecs[3].data[i*8 +: 8] = 8'(i*7 + 1);
    model_mem = '0;

    // reset state, then idle with no start
    repeat (3) @(negedge clk);
    chk("rst_mem", mem, '0);
    chk("rst_hold", MW'(cpu_hold), MW'(1'b1));
    chk("rst_done", MW'(done), MW'(1'b0));
    chk("rst_in_ready", MW'(in_ready), MW'(1'b0));
    chk("rst_busy", MW'(busy), MW'(1'b0));
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_mem", mem, '0);
    chk("idle_hold", MW'(cpu_hold), MW'(1'b1));
    chk("idle_done", MW'(done), MW'(1'b0));
    chk("idle_in_ready", MW'(in_ready), MW'(1'b0));
    chk("idle_busy", MW'(busy), MW'(1'b0));

    // table-driven loads
    run_vec(vecs[0], "v0");
    chk("v0_low_word", MW'(mem[31:0]), MW'(32'h44332211));
    run_vec(vecs[1], "v1_wrap");
    chk("v1_byte14", MW'(mem[14*8 +: 8]), MW'(8'hAA));
    chk("v1_byte15", MW'(mem[15*8 +: 8]), MW'(8'hBB));
    chk("v1_byte0", MW'(mem[7:0]), MW'(8'hCC));
    chk("v1_byte1_kept", MW'(mem[15:8]), MW'(8'h22));
    run_vec(vecs[2], "v2_count0");
    run_vec(vecs[3], "v3_full");
    run_vec(vecs[4], "v4");
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    run_vec(vecs[5], "v5_bad_ck");
`endif

    // start pulsed mid-load is ignored
    v = '{base: 4'd2, cnt: 5'd4, data: 128'h64636261, gap: 0, ck_bad: 1'b0};
    push_expect(v);
    begin_load(v.base, v.cnt);
    send_byte(8'h61, 0);
    send_byte(8'h62, 0);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1; base_addr = 4'd10; count = 5'd1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_busy", MW'(busy), MW'(1'b1));
    chk("midstart_done", MW'(done), MW'(1'b0));
    send_byte(8'h63, 0);
    send_byte(8'h64, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(ck_byte(payload_sum(v), 1'b0), 0);
`endif
    finish_load("midstart");

    // reset in the middle of a load
    begin_load(4'd0, 5'd4);
    send_byte(8'h99, 0);
    send_byte(8'h98, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    model_mem = '0;
    chk("midrst_mem", mem, '0);
    chk("midrst_busy", MW'(busy), MW'(1'b0));
    chk("midrst_hold", MW'(cpu_hold), MW'(1'b1));
    chk("midrst_done", MW'(done), MW'(1'b0));
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[0], "after_rst");

    chk("sb_empty", MW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
